// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_if
//  Purpose  : Instruction-memory read bus between the fetch stage (master)
//             and the instruction memory (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction fetch stage. Requests one word from instruction
//             memory, buffers it and presents it to ID until it is consumed
//             or a redirect arrives. Two-state FSM: S_REQ / S_HOLD.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire               clk,
  input  wire               clr_n,
  input  wire               en,
  input  wire               stall,
  input  wire               condition_met,
  input  wire        [31:0] target_pc,
  if_fetch_if.master        imem,
  output logic       [31:0] IF_pc_add4,
  output logic       [31:0] IF_inst,
  output logic              IF_valid,
  output logic              fetch_busy
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] w_pc_add4;

  // Plain 32-bit add: the carry out is dropped, so the PC wraps at 2^32.
  assign w_pc_add4 = pc_q + 32'd4;

  // State, PC and instruction buffer; reset abandons everything at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next state: en=0 freezes, redirect beats ack/consumption, stall only
  // matters while an instruction is being offered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (en) begin
      if (condition_met) begin
        // Redirect drops the buffered word and any same-cycle ack.
        pc_d    = target_pc & c_ALIGN_MASK;
        buf_d   = 32'd0;
        state_d = S_REQ;
      end else if (state_q == S_REQ) begin
        if (imem.imem_ack) begin
          buf_d   = imem.imem_rdata;
          state_d = S_HOLD;
        end
      end else if (!stall) begin
        pc_d    = w_pc_add4;
        state_d = S_REQ;
      end
    end
  end

  // Request is gated by reset so the bus is quiet while clr_n is low.
  assign imem.imem_req  = (state_q == S_REQ) && en && clr_n;
  assign imem.imem_addr = pc_q;

  assign IF_valid   = (state_q == S_HOLD);
  assign fetch_busy = ~IF_valid;
  assign IF_inst    = IF_valid ? buf_q     : 32'd0;
  assign IF_pc_add4 = IF_valid ? w_pc_add4 : 32'd0;

endmodule
`default_nettype wire
